// File: rtl/cc_frame_sequencer_pkg.sv
// CCHW: shared types for the frame sequencer.
// Holds the state enum and the 3-bit encoding exported on stateOut.
package CCHW;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_DELAY    = 3'd1,
    ST_WAIT_NF  = 3'd2,
    ST_WAIT_LV  = 3'd3,
    ST_WAIT_LED = 3'd4
  } state_t;

endpackage

// File: rtl/cc_frame_sequencer.sv
// cc_frame_sequencer: per-frame start sequencing for NoteFinder,
// LinearVisualizer and the LED driver channels.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | waiting for a divided sample-read trigger
//   ST_DELAY    | down-counting to the NoteFinder start
//   ST_WAIT_NF  | NoteFinder running, waiting for nfDone
//   ST_WAIT_LV  | visualizer running, waiting for lvDone
//   ST_WAIT_LED | LED drivers running, collecting per-channel done flags
//
// Optional build macro CC_SEQ_WATCHDOG_EN adds a wait-state watchdog
// that aborts the frame and raises a sticky timeout flag.
module cc_frame_sequencer
  import CCHW::*;
#(
  parameter int CHANNELS    = 2,
  parameter int START_DELAY = 4,
  parameter int FRAME_DIV   = 1,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sampleRead,
  output logic                nfStart,
  input  logic                nfDone,
  output logic                lvStart,
  input  logic                lvDone,
  output logic [CHANNELS-1:0] ledStart,
  input  logic [CHANNELS-1:0] ledDone,
  output logic                busy,
  output logic [CNT_W-1:0]    frameCount,
  output logic [CNT_W-1:0]    dropCount,
  output logic                timeout,
  output logic [2:0]          stateOut
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int DLY_W = 8;

  // Reject out-of-range configuration at elaboration.
  if (CHANNELS < 1 || CHANNELS > 8 || START_DELAY < 1 || START_DELAY > 255 ||
      FRAME_DIV < 1 || FRAME_DIV > 65535 || CNT_W < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("cc_frame_sequencer: parameter out of range");
  end

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [CHANNELS-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]    frame_q, drop_q;
  logic                nf_start_q, lv_start_q;
  logic [CHANNELS-1:0] led_start_q;
  logic                trigger;
  logic                done_all;
  logic                frame_inc;
  logic                drop_inc;
  logic                lv_fire;
  logic                led_fire;

`ifdef CC_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;
  logic            wdog_fire;
  logic            timeout_q;
  logic            in_wait;
  assign in_wait = (state_q == ST_WAIT_NF) || (state_q == ST_WAIT_LV) ||
                   (state_q == ST_WAIT_LED);
`endif

  // The divider runs in every state; the pulse that reaches FRAME_DIV fires.
  assign trigger  = sampleRead && (div_q == DIV_W'(FRAME_DIV - 1));
  assign div_d    = trigger ? '0 : (sampleRead ? div_q + 1'b1 : div_q);
  assign done_all = &(flags_q | ledDone);

  // Next-state, delay counter, done-flag and counter-event decode.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    flags_d   = flags_q;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    lv_fire   = 1'b0;
    led_fire  = 1'b0;
`ifdef CC_SEQ_WATCHDOG_EN
    wdog_fire = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_DELAY;
          dly_d   = DLY_W'(START_DELAY - 1);
        end
      end
      ST_DELAY: begin
        drop_inc = trigger;
        if (dly_q == '0) state_d = ST_WAIT_NF;
        else             dly_d   = dly_q - 1'b1;
      end
      ST_WAIT_NF: begin
        drop_inc = trigger;
        if (nfDone) begin
          state_d = ST_WAIT_LV;
          lv_fire = 1'b1;
        end
      end
      ST_WAIT_LV: begin
        drop_inc = trigger;
        if (lvDone) begin
          state_d  = ST_WAIT_LED;
          led_fire = 1'b1;
          flags_d  = '0;
        end
      end
      ST_WAIT_LED: begin
        flags_d = flags_q | ledDone;
        if (done_all) begin
          frame_inc = 1'b1;
          // A trigger landing on the completion cycle starts the next frame.
          if (trigger) begin
            state_d = ST_DELAY;
            dly_d   = DLY_W'(START_DELAY - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          drop_inc = trigger;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef CC_SEQ_WATCHDOG_EN
    // A legitimate handshake in the expiry cycle takes precedence.
    if (in_wait && (state_d == state_q) && (wdog_q == WD_W'(WDOG_CYCLES - 1))) begin
      state_d   = ST_IDLE;
      wdog_fire = 1'b1;
    end
`endif
  end

  // State, counters and registered start pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      dly_q       <= '0;
      flags_q     <= '0;
      frame_q     <= '0;
      drop_q      <= '0;
      nf_start_q  <= 1'b0;
      lv_start_q  <= 1'b0;
      led_start_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      dly_q       <= dly_d;
      flags_q     <= flags_d;
      nf_start_q  <= (state_d == ST_DELAY) && (dly_d == '0);
      lv_start_q  <= lv_fire;
      led_start_q <= {CHANNELS{led_fire}};
      if (frame_inc) frame_q <= frame_q + 1'b1;
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

`ifdef CC_SEQ_WATCHDOG_EN
  // Watchdog counts residency in wait states; any state change restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q) wdog_q <= '0;
      else if (in_wait)       wdog_q <= wdog_q + 1'b1;
      if (wdog_fire) timeout_q <= 1'b1;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign nfStart    = nf_start_q;
  assign lvStart    = lv_start_q;
  assign ledStart   = led_start_q;
  assign busy       = (state_q != ST_IDLE);
  assign frameCount = frame_q;
  assign dropCount  = drop_q;
  assign stateOut   = state_q;

endmodule

// File: tb/tb_cc_frame_sequencer.sv
// Bench for cc_frame_sequencer: two instances with different parameters
// share stimulus; a cycle-indexed event model predicts every output.
module tb_cc_frame_sequencer;
  import CCHW::*;

  localparam int CH = 2;
  localparam int WD = 50;

  int P_FD [2] = '{1, 3};
  int P_SD [2] = '{4, 1};
  int P_CW [2] = '{16, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sr = 1'b0, nfd = 1'b0, lvd = 1'b0;
  logic [CH-1:0] ledd = '0;

  logic          nf_start [2];
  logic          lv_start [2];
  logic [CH-1:0] led_start [2];
  logic          busy [2];
  logic          tmo [2];
  logic [2:0]    state_out [2];
  logic [15:0]   frame_a, drop_a;
  logic [1:0]    frame_b, drop_b;

  always #5 clk = ~clk;

  cc_frame_sequencer #(.CHANNELS(CH), .START_DELAY(4), .FRAME_DIV(1), .CNT_W(16), .WDOG_CYCLES(WD)) u_a (
    .clk(clk), .rst(rst), .sampleRead(sr), .nfStart(nf_start[0]), .nfDone(nfd),
    .lvStart(lv_start[0]), .lvDone(lvd), .ledStart(led_start[0]), .ledDone(ledd),
    .busy(busy[0]), .frameCount(frame_a), .dropCount(drop_a), .timeout(tmo[0]),
    .stateOut(state_out[0]));

  cc_frame_sequencer #(.CHANNELS(CH), .START_DELAY(1), .FRAME_DIV(3), .CNT_W(2), .WDOG_CYCLES(WD)) u_b (
    .clk(clk), .rst(rst), .sampleRead(sr), .nfStart(nf_start[1]), .nfDone(nfd),
    .lvStart(lv_start[1]), .lvDone(lvd), .ledStart(led_start[1]), .ledDone(ledd),
    .busy(busy[1]), .frameCount(frame_b), .dropCount(drop_b), .timeout(tmo[1]),
    .stateOut(state_out[1]));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nf_cnt [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h expected=%0h", nm, inst, cyc, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 delaying, 2 nf wait, 3 lv wait, 4 led wait.
  int      m_div [2], m_phase [2], m_nf_at [2], m_entry [2];
  longint  m_frames [2], m_drops [2];
  bit      m_lv [2], m_led [2], m_to [2];
  bit [CH-1:0] m_flags [2];

  function automatic logic [2:0] phase_code(int p);
    case (p)
      1:       return 3'(ST_DELAY);
      2:       return 3'(ST_WAIT_NF);
      3:       return 3'(ST_WAIT_LV);
      4:       return 3'(ST_WAIT_LED);
      default: return 3'(ST_IDLE);
    endcase
  endfunction

  task automatic mdl_reset(input int i);
    m_div[i] = 0; m_phase[i] = 0; m_nf_at[i] = -1; m_entry[i] = 0;
    m_frames[i] = 0; m_drops[i] = 0; m_lv[i] = 0; m_led[i] = 0; m_to[i] = 0;
    m_flags[i] = '0;
  endtask

  task automatic mdl_step(input int i, input int c);
    bit trig, accepted, moved;
    bit [CH-1:0] f;
    trig = sr && (m_div[i] + 1 == P_FD[i]);
    if (sr) m_div[i] = trig ? 0 : m_div[i] + 1;
    m_lv[i] = 0; m_led[i] = 0;
    accepted = 0; moved = 0;
    case (m_phase[i])
      0: if (trig) begin
           accepted = 1; m_phase[i] = 1; m_nf_at[i] = c + P_SD[i];
         end
      1: if (c == m_nf_at[i]) begin m_phase[i] = 2; m_entry[i] = c + 1; end
      2: if (nfd) begin m_phase[i] = 3; m_entry[i] = c + 1; m_lv[i] = 1; moved = 1; end
      3: if (lvd) begin m_phase[i] = 4; m_entry[i] = c + 1; m_led[i] = 1; m_flags[i] = '0; moved = 1; end
      4: begin
           f = m_flags[i] | ledd;
           m_flags[i] = f;
           if (f == '1) begin
             moved = 1;
             m_frames[i]++;
             if (trig) begin accepted = 1; m_phase[i] = 1; m_nf_at[i] = c + P_SD[i]; end
             else m_phase[i] = 0;
           end
         end
      default: ;
    endcase
`ifdef CC_SEQ_WATCHDOG_EN
    if (!moved && m_phase[i] >= 2 && (c - m_entry[i] + 1) >= WD) begin
      m_phase[i] = 0; m_to[i] = 1;
    end
`endif
    if (trig && !accepted) m_drops[i]++;
  endtask

  // Per-cycle compare against the model, then advance it with this cycle's inputs.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      longint mask;
      logic [31:0] fr, dr;
      mask = (64'd1 << P_CW[i]) - 1;
      if (!rst) mdl_reset(i);
      fr = (i == 0) ? 32'(frame_a) : 32'(frame_b);
      dr = (i == 0) ? 32'(drop_a)  : 32'(drop_b);
      chk("nfStart",    i, 32'(nf_start[i]),  32'(m_phase[i] == 1 && cyc == m_nf_at[i]));
      chk("lvStart",    i, 32'(lv_start[i]),  32'(m_lv[i]));
      chk("ledStart",   i, 32'(led_start[i]), m_led[i] ? 32'(2'b11) : 32'd0);
      chk("busy",       i, 32'(busy[i]),      32'(m_phase[i] != 0));
      chk("stateOut",   i, 32'(state_out[i]), 32'(phase_code(m_phase[i])));
      chk("frameCount", i, fr, 32'(m_frames[i] & mask));
      chk("dropCount",  i, dr, 32'((m_drops[i] > mask) ? mask : m_drops[i]));
      chk("timeout",    i, 32'(tmo[i]),       32'(m_to[i]));
      nf_cnt[i] += int'(nf_start[i]);
      if (rst) mdl_step(i, cyc);
    end
  end

  task automatic step(input bit s, input bit n, input bit l, input logic [CH-1:0] d);
    @(posedge clk); #1;
    sr = s; nfd = n; lvd = l; ledd = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; sr = 0; nfd = 0; lvd = 0; ledd = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int base_nf;
    for (int i = 0; i < 2; i++) mdl_reset(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  0, 32'(busy[0]), 32'd0);
    chk("rst_frame", 0, 32'(frame_a), 32'd0);
    rst = 1'b1;

    // Reference frame on instance A: trigger, delay 4, handshakes, two LED channels.
    do_reset();
    for (int k = 0; k <= 26; k++) begin
      step(k == 0, k == 10, k == 15, {k == 25, k == 20});
      if (k == 3 || k == 5) chk("nf_quiet", 0, 32'(nf_start[0]), 32'd0);
      if (k == 4)  chk("nf_at_4",   0, 32'(nf_start[0]),  32'd1);
      if (k == 11) chk("lv_at_11",  0, 32'(lv_start[0]),  32'd1);
      if (k == 16) chk("led_at_16", 0, 32'(led_start[0]), 32'(2'b11));
      if (k == 26) begin
        chk("frame_at_26", 0, 32'(frame_a), 32'd1);
        chk("idle_at_26",  0, 32'(busy[0]), 32'd0);
      end
    end

    // Divide-by-3 on instance B: six triggers with complete frames between.
    do_reset();
    base_nf = nf_cnt[1];
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 10; k++) begin
        step(k == 0, k == 3, k == 5, (k == 7) ? 2'b11 : 2'b00);
        if (k == 1) chk("fd3_nf", 1, 32'(nf_start[1]), 32'(j == 2 || j == 5));
      end
    end
    chk("fd3_count", 1, 32'(nf_cnt[1] - base_nf), 32'd2);

    // Drops while B waits on nfDone; 2-bit drop counter must saturate.
    base_nf = nf_cnt[1];
    for (int p = 0; p < 18; p++) begin
      step(1, 0, 0, '0);
      step(0, 0, 0, '0);
    end
    chk("drop_sat", 1, 32'(drop_b), 32'd3);
    chk("drop_no_nf", 1, 32'(nf_cnt[1] - base_nf), 32'd1);

    // Completion and trigger in the same cycle on A, then async reset in WAIT_LV.
    do_reset();
    for (int k = 0; k <= 19; k++) begin
      step(k == 0 || k == 11, k == 6 || k == 17, k == 8, (k == 11) ? 2'b11 : 2'b00);
      if (k == 12) begin
        chk("merge_state", 0, 32'(state_out[0]), 32'(ST_DELAY));
        chk("merge_frame", 0, 32'(frame_a), 32'd1);
        chk("merge_drop",  0, 32'(drop_a),  32'd0);
      end
      if (k == 15) chk("merge_nf", 0, 32'(nf_start[0]), 32'd1);
      if (k == 19) chk("pre_rst_state", 0, 32'(state_out[0]), 32'(ST_WAIT_LV));
    end
    @(posedge clk); #1;
    sr = 0; nfd = 0; lvd = 0; ledd = '0;
    rst = 1'b0;
    #2;
    chk("arst_state", 0, 32'(state_out[0]), 32'(ST_IDLE));
    chk("arst_busy",  0, 32'(busy[0]),      32'd0);
    chk("arst_frame", 0, 32'(frame_a),      32'd0);
    chk("arst_starts", 0, {29'd0, nf_start[0], lv_start[0], |led_start[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; lvd = 1'b1;
    step(0, 0, 0, '0);
    chk("post_rst_lv_ignored", 0, 32'(state_out[0]), 32'(ST_IDLE));
    chk("post_rst_no_led",     0, 32'(led_start[0]), 32'd0);

    // Withheld nfDone on A.
    do_reset();
    for (int k = 0; k <= 70; k++) begin
      step(k == 0, 0, 0, '0);
      if (k == 40) chk("wd_waiting", 0, 32'(state_out[0]), 32'(ST_WAIT_NF));
      if (k == 60) begin
`ifdef CC_SEQ_WATCHDOG_EN
        chk("wd_state",   0, 32'(state_out[0]), 32'(ST_IDLE));
        chk("wd_timeout", 0, 32'(tmo[0]),       32'd1);
`else
        chk("wd_state",   0, 32'(state_out[0]), 32'(ST_WAIT_NF));
        chk("wd_timeout", 0, 32'(tmo[0]),       32'd0);
`endif
        chk("wd_frame", 0, 32'(frame_a), 32'd0);
      end
    end

    // Random traffic with occasional mid-frame resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) begin
        @(posedge clk); #1;
        rst = 1'b0; sr = 0; nfd = 0; lvd = 0; ledd = '0;
        @(posedge clk); #1;
        rst = 1'b1;
      end else begin
        step($urandom_range(99) < 30, $urandom_range(99) < 20, $urandom_range(99) < 20,
             {$urandom_range(99) < 25, $urandom_range(99) < 25});
      end
    end

    repeat (3) step(0, 0, 0, '0);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cc_frame_sequencer.md
CC_FRAME_SEQUENCER -- requirements
Module: cc_frame_sequencer

Interface
REQ-001 Parameter CHANNELS, 2, number of independent LED output driver channels sequenced per frame (1..8).
REQ-002 Parameter START_DELAY, 4, cycles from accepted sample-read pulse to nfStart pulse (1..255).
REQ-003 Parameter FRAME_DIV, 1, process every FRAME_DIV-th sample-read pulse (1..65535).
REQ-004 Parameter CNT_W, 16, width of frameCount and dropCount.
REQ-005 Parameter WDOG_CYCLES, 1000000, maximum cycles allowed in any wait state (watchdog build only).
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-008 sampleRead  input  1  one-cycle pulse per DFT sample read.
REQ-009 nfStart  output  1  one-cycle start pulse to NoteFinder.
REQ-010 nfDone  input  1  NoteFinder finished pulse.
REQ-011 lvStart  output  1  one-cycle start pulse to LinearVisualizer.
REQ-012 lvDone  input  1  visualizer data-valid pulse.
REQ-013 ledStart  output  CHANNELS  per-channel one-cycle LED driver start.
REQ-014 ledDone  input  CHANNELS  per-channel LED driver done pulses.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 frameCount  output  CNT_W  completed frames, wraps at 2^CNT_W.
REQ-017 dropCount  output  CNT_W  triggers dropped while busy, saturates at all-ones.
REQ-018 timeout  output  1  sticky watchdog flag; constant 0 without watchdog build.
REQ-019 stateOut  output  3  current state encoding for debug.

Function
REQ-020 States: IDLE, DELAY, WAIT_NF, WAIT_LV, WAIT_LED; transitions only as below.
REQ-021 Divider counts sampleRead pulses in every state; trigger fires on the pulse that brings it to FRAME_DIV, divider then clears to 0.
REQ-022 Trigger in IDLE: go to DELAY, load delay counter with START_DELAY-1.
REQ-023 DELAY: counter decrements; at 0, nfStart=1 that cycle, go WAIT_NF; nfStart asserts exactly START_DELAY cycles after the trigger pulse.
REQ-024 WAIT_NF: on nfDone, lvStart=1 next cycle, go WAIT_LV.
REQ-025 WAIT_LV: on lvDone, all ledStart bits=1 next cycle, clear per-channel done flags, go WAIT_LED.
REQ-026 WAIT_LED: per-channel sticky done flags set by ledDone; when all flags are set (including the current cycle's pulses), increment frameCount, go IDLE.
REQ-027 Trigger while not IDLE increments dropCount (saturating) and is otherwise ignored, except a trigger coinciding with the WAIT_LED completion cycle is accepted and DELAY is entered directly.
REQ-028 Done pulses arriving in a state that is not waiting for them are ignored.
REQ-029 Start outputs are registered, never asserted for more than one consecutive cycle.

Reset
REQ-030 Reset assertion forces IDLE immediately, regardless of clock and state, mid-frame included.
REQ-031 Reset values: nfStart=0, lvStart=0, ledStart=0, busy=0, frameCount=0, dropCount=0, timeout=0, stateOut=IDLE; divider, delay counter, done flags and watchdog counter all 0.
REQ-032 First trigger after reset deassertion requires FRAME_DIV fresh pulses.

Configuration
REQ-033 Macro CC_SEQ_WATCHDOG_EN: when defined, a counter clears on each state entry and increments in WAIT_NF, WAIT_LV and WAIT_LED; reaching WDOG_CYCLES forces IDLE, sets timeout and does not count a frame.
REQ-034 Without CC_SEQ_WATCHDOG_EN: no watchdog counter is synthesised, timeout is tied to 0, and wait states wait indefinitely.

Structure
REQ-035 Package CCHW holds the state enum typedef and the stateOut encoding.
REQ-036 Single module; no sub-modules; the divider, delay counter and watchdog are inline counters.

Verification
REQ-037 FRAME_DIV=1, START_DELAY=4, CHANNELS=2: pulse sampleRead at cycle 10 -> nfStart high at cycle 14 only; nfDone at 20 -> lvStart at 21; lvDone at 25 -> ledStart=2'b11 at 26; ledDone[0] at 30 and ledDone[1] at 35 -> frameCount=1 and busy=0 at 36.
REQ-038 FRAME_DIV=3: 6 sampleRead pulses with the sequencer idle -> exactly 2 nfStart pulses, on the 3rd and 6th triggers plus START_DELAY.
REQ-039 Busy in WAIT_NF plus 3 triggers -> dropCount=3 and no extra nfStart; with CNT_W=2, 5 drops -> dropCount holds 3.
REQ-040 Both ledDone bits in one cycle, coinciding with a trigger -> frameCount increments, state goes to DELAY, dropCount unchanged.
REQ-041 Drive rst low in WAIT_LV between clock edges -> all outputs at reset values before the next edge; the following lvDone is ignored.
REQ-042 Watchdog build, WDOG_CYCLES=50, nfDone withheld -> IDLE and timeout=1 after 50 cycles in WAIT_NF, frameCount unchanged; non-watchdog build -> stays in WAIT_NF, timeout=0.
